// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline slice: the memory-stage FSM state,
// the datapath widths, and the bundle of memory-related control bits that
// travels from ID/EX into EX/MEM.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Memory-access FSM state
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE_ERR
  } mem_state_t;

  // Memory-related control bits from ID/EX
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. The count stops at the
// all-ones value.
//   clk_i  : clock
//   clr_i  : synchronous clear (has priority over inc_i)
//   inc_i  : add one this cycle, unless already saturated
//   cnt_o  : current count
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, runs a req/ack handshake to a variable-latency
// data memory, stalls the upstream stages while an access is outstanding, and
// produces the MEM/WB register with the write-back data mux. A timeout
// force-completes an access to a dead memory and flags an error.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   ex_*                  : ALU result / store data / rd / control from ID/EX
//   mem_*                 : data-memory port (req, we, word addr, wdata, rdata, ack)
//   stall_o               : freezes PC, IF/ID and ID/EX
//   fwd_mem_*             : EX/MEM values for the forwarding unit
//   wb_*                  : MEM/WB values for the register file and forwarding
//   bus_err_o             : sticky timeout / misalignment error, cleared by reset
//   load/store/stall_cnt_o: saturating performance counters
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W-1:0]     ex_alu_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic                  ex_memtoreg_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_memwrite_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  stall_o,
  output logic [REG_ADDR_W-1:0] fwd_mem_rd_o,
  output logic                  fwd_mem_regwrite_o,
  output logic [DATA_W-1:0]     fwd_mem_alu_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  wb_regwrite_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  bus_err_o,
  output logic [CNT_W-1:0]      load_cnt_o,
  output logic [CNT_W-1:0]      store_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // EX/MEM register
  logic [DATA_W-1:0]     exm_alu;
  logic [DATA_W-1:0]     exm_wdata;
  logic [REG_ADDR_W-1:0] exm_rd;
  mem_ctrl_t             exm_ctrl;

  // MEM/WB register
  logic [REG_ADDR_W-1:0] mwb_rd;
  logic                  mwb_regwrite;
  logic [DATA_W-1:0]     mwb_data;

  mem_state_t state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          bus_err;

  logic              mem_op;
  logic              in_err;
  logic              stall;
  logic              to_err;
  logic              misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_data_nxt;

  always_comb begin
    mem_op      = exm_ctrl.memread | exm_ctrl.memwrite;
    in_err      = (state == DONE_ERR);
    stall       = mem_op & ~mem_ack_i & ~in_err;
    misaligned  = mem_op & (exm_alu[1:0] != 2'b00);
    load_data   = in_err ? '0 : mem_rdata_i;
    wb_data_nxt = exm_ctrl.memtoreg ? load_data : exm_alu;

    state_nxt = state;
    tcnt_nxt  = tcnt;
    to_err    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !mem_ack_i) begin
          state_nxt = WAIT;
          tcnt_nxt  = TW'(1);
        end
      end
      WAIT: begin
        // tcnt counts stalled cycles including the one spent in IDLE, so
        // the total stall is exactly TIMEOUT cycles before DONE_ERR.
        if (mem_ack_i) begin
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
          if (tcnt_nxt == TW'(TIMEOUT)) begin
            state_nxt = DONE_ERR;
            to_err    = 1'b1;
          end
        end
      end
      DONE_ERR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tcnt         <= '0;
      bus_err      <= 1'b0;
      exm_alu      <= '0;
      exm_wdata    <= '0;
      exm_rd       <= '0;
      exm_ctrl     <= '0;
      mwb_rd       <= '0;
      mwb_regwrite <= 1'b0;
      mwb_data     <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (to_err || misaligned) begin
        bus_err <= 1'b1;
      end
      if (!stall) begin
        exm_alu   <= ex_alu_i;
        exm_wdata <= ex_wdata_i;
        exm_rd    <= ex_rd_i;
        exm_ctrl  <= '{regwrite: ex_regwrite_i, memtoreg: ex_memtoreg_i,
                       memread:  ex_memread_i,  memwrite: ex_memwrite_i};
        mwb_rd       <= exm_rd;
        mwb_regwrite <= exm_ctrl.regwrite;
        mwb_data     <= wb_data_nxt;
      end else begin
        // Bubble while stalled so the held instruction writes back once.
        mwb_rd       <= '0;
        mwb_regwrite <= 1'b0;
        mwb_data     <= '0;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_load_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (~stall & exm_ctrl.memread),
    .cnt_o (load_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (~stall & exm_ctrl.memwrite),
    .cnt_o (store_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (stall),
    .cnt_o (stall_cnt_o)
  );

  assign mem_req_o          = mem_op & ~in_err;
  assign mem_we_o           = exm_ctrl.memwrite;
  assign mem_addr_o         = {exm_alu[DATA_W-1:2], 2'b00};
  assign mem_wdata_o        = exm_wdata;
  assign stall_o            = stall;
  assign fwd_mem_rd_o       = exm_rd;
  assign fwd_mem_regwrite_o = exm_ctrl.regwrite;
  assign fwd_mem_alu_o      = exm_alu;
  assign wb_rd_o            = mwb_rd;
  assign wb_regwrite_o      = mwb_regwrite;
  assign wb_data_o          = mwb_data;
  assign bus_err_o          = bus_err;

endmodule
